// File: rtl/hazard_pkg.sv
// Shared encodings for the ARM/RISC-V hazard unit.
// Forwarding mux selects and fixed register numbers.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_e;

  localparam int ARM_PC_REG  = 15;
  localparam int RV_ZERO_REG = 0;

endpackage

// File: rtl/hz_scoreboard.sv
// Pending-destination tracker for the multi-cycle unit.
// A set in the same cycle as a clear of one register wins.
module hz_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic             set_pend,
  input  logic [AW-1:0]    set_rd,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_rd,
  output logic [NREGS-1:0] pending,
  output logic             busy
);

  // Clear first, then set, so a same-cycle set overrides the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      busy    <= 1'b0;
    end else begin
      if (clr_en) begin
        pending[clr_rd] <= 1'b0;
        busy            <= 1'b0;
      end
      if (set_en) begin
        if (set_pend)
          pending[set_rd] <= 1'b1;
        busy <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: forwarding, load-use and multi-cycle stalls,
// control flushes and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NREGS = 32,
  parameter  int NRD   = 3,
  parameter  int CW    = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic [NRD-1:0][AW-1:0]  RsD,
  input  logic [NRD-1:0]          RsUseD,
  input  logic [NRD-1:0][AW-1:0]  RsE,
  input  logic [NRD-1:0]          RsUseE,
  input  logic [AW-1:0]           RdE,
  input  logic [AW-1:0]           RdM,
  input  logic [AW-1:0]           RdW,
  input  logic                    RegWriteE,
  input  logic                    RegWriteM,
  input  logic                    RegWriteW,
  input  logic                    LoadE,
  input  logic                    McStartE,
  input  logic                    McDone,
  input  logic [AW-1:0]           McRd,
  input  logic                    RVPCSrcE,
  input  logic                    PCSrcD,
  input  logic                    PCSrcE,
  input  logic                    PCSrcM,
  input  logic                    PCSrcW,
  input  logic                    BranchTakenE,
  output logic [NRD-1:0][1:0]     ForwardE,
  output logic                    StallF,
  output logic                    StallD,
  output logic                    FlushD,
  output logic                    FlushE,
  output logic                    McBusy,
  output logic [CW-1:0]           StallCycles
);

  localparam logic [AW-1:0] PC_REG = AW'(ARM_PC_REG);
  localparam logic [AW-1:0] X0_REG = AW'(RV_ZERO_REG);

  logic [NREGS-1:0] pending;
  logic             ld_hit;
  logic             pend_hit;
  logic             ld_stall;
  logic             sc_stall;
  logic             stall_d;
  logic             set_en;
  logic             set_pend;

  // PC in ARM and x0 in RISC-V are never real dependencies.
  function automatic logic src_ok(
    input logic          a,
    input logic [AW-1:0] r
  );
    return a ? (r != PC_REG) : (r != X0_REG);
  endfunction

  // Per-port E-stage forwarding; M beats W.
  always_comb begin
    ForwardE = '0;
    for (int p = 0; p < NRD; p++) begin
      logic ok;
      ok = RsUseE[p] & src_ok(arm, RsE[p]) & ~reset;
      priority case (1'b1)
        ok & RegWriteM & (RsE[p] == RdM): ForwardE[p] = FWD_M;
        ok & RegWriteW & (RsE[p] == RdW): ForwardE[p] = FWD_W;
        default:                          ForwardE[p] = FWD_RF;
      endcase
    end
  end

  // Decode-side dependency on the E load and on pending results.
  always_comb begin
    ld_hit   = 1'b0;
    pend_hit = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      if (RsUseD[p] && src_ok(arm, RsD[p])) begin
        if (RsD[p] == RdE)
          ld_hit = 1'b1;
        if (pending[RsD[p]])
          pend_hit = 1'b1;
      end
    end
  end

  assign ld_stall = LoadE & RegWriteE & ld_hit;
  assign sc_stall = pend_hit | (McStartE & McBusy & ~McDone);
  assign stall_d  = ~reset & (ld_stall | sc_stall);

  assign StallD = stall_d;
  assign StallF = ~reset &
    (stall_d | (arm & (PCSrcD | PCSrcE | PCSrcM)));
  assign FlushE = reset | ld_stall | sc_stall |
    (arm & BranchTakenE) | (~arm & RVPCSrcE);
  assign FlushD = reset | (arm
    ? (PCSrcD | PCSrcE | PCSrcM | PCSrcW | BranchTakenE)
    : RVPCSrcE);

  assign set_en   = McStartE & ~stall_d;
  assign set_pend = arm | (RdE != X0_REG);

  hz_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (set_en),
    .set_pend (set_pend),
    .set_rd   (RdE),
    .clr_en   (McDone),
    .clr_rd   (McRd),
    .pending  (pending),
    .busy     (McBusy)
  );

  // Stall cycle count, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset)
      StallCycles <= '0;
    else if (stall_d && (StallCycles != '1))
      StallCycles <= StallCycles + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard.
// Expected values are queued at drive time, popped at negedge.
module tb_hazard_scoreboard;

  localparam int NREGS = 32;
  localparam int NRD   = 3;
  localparam int CW    = 16;
  localparam int AW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic                   arm;
  logic [NRD-1:0][AW-1:0] RsD;
  logic [NRD-1:0]         RsUseD;
  logic [NRD-1:0][AW-1:0] RsE;
  logic [NRD-1:0]         RsUseE;
  logic [AW-1:0]          RdE, RdM, RdW;
  logic                   RegWriteE, RegWriteM, RegWriteW;
  logic                   LoadE, McStartE, McDone;
  logic [AW-1:0]          McRd;
  logic                   RVPCSrcE;
  logic                   PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic                   BranchTakenE;
  logic [NRD-1:0][1:0]    ForwardE;
  logic                   StallF, StallD, FlushD, FlushE;
  logic                   McBusy;
  logic [CW-1:0]          StallCycles;

  int n_run  = 0;
  int n_fail = 0;

  logic                stall_q[$];
  logic [NRD-1:0][1:0] fwd_q[$];
  logic [2:0]          ctl_q[$];

  hazard_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .CW    (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .RsD          (RsD),
    .RsUseD       (RsUseD),
    .RsE          (RsE),
    .RsUseE       (RsUseE),
    .RdE          (RdE),
    .RdM          (RdM),
    .RdW          (RdW),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .LoadE        (LoadE),
    .McStartE     (McStartE),
    .McDone       (McDone),
    .McRd         (McRd),
    .RVPCSrcE     (RVPCSrcE),
    .PCSrcD       (PCSrcD),
    .PCSrcE       (PCSrcE),
    .PCSrcM       (PCSrcM),
    .PCSrcW       (PCSrcW),
    .BranchTakenE (BranchTakenE),
    .ForwardE     (ForwardE),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .McBusy       (McBusy),
    .StallCycles  (StallCycles)
  );

  task automatic idle();
    RsD = '0; RsUseD = '0; RsE = '0; RsUseE = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    LoadE = 0; McStartE = 0; McDone = 0; McRd = '0;
    RVPCSrcE = 0; PCSrcD = 0; PCSrcE = 0; PCSrcM = 0;
    PCSrcW = 0; BranchTakenE = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; arm = 0; idle();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; arm = 1; idle();
    LoadE = 1; RegWriteE = 1; RdE = 7;
    RsD[0] = 7; RsUseD = 3'b001;
    RegWriteM = 1; RdM = 5; RsE[0] = 5; RsUseE = 3'b001;
    PCSrcD = 1;
    @(negedge clk);
    n_run++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
      n_fail++;
      $display("FAIL rst_ctl: got %b want 0011",
        {StallF, StallD, FlushD, FlushE});
    end
    n_run++;
    if (ForwardE !== '0) begin
      n_fail++;
      $display("FAIL rst_fwd: got %h want 0", ForwardE);
    end
    tick();
    reset = 0; arm = 0; idle();
    @(negedge clk);
    n_run++;
    if ({McBusy, StallD, FlushD, FlushE} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_rel: got %b want 0000",
        {McBusy, StallD, FlushD, FlushE});
    end
    n_run++;
    if (StallCycles !== '0) begin
      n_fail++;
      $display("FAIL rst_cnt: got %0d want 0", StallCycles);
    end
    tick();
  endtask

  typedef struct {
    logic [AW-1:0] rdm;
    logic          wm;
    logic [AW-1:0] rdw;
    logic          ww;
    logic [AW-1:0] rs;
    logic          use_p;
    int            port;
    logic [1:0]    code;
  } fwd_pat_t;

  task automatic test_forward();
    fwd_pat_t pats[7];
    logic [NRD-1:0][1:0] e;
    logic [NRD-1:0][1:0] got;
    pats[0] = '{5, 1, 0, 0, 5, 1, 0, 2'b10};
    pats[1] = '{6, 1, 5, 1, 5, 1, 0, 2'b01};
    pats[2] = '{0, 1, 0, 1, 0, 1, 0, 2'b00};
    pats[3] = '{5, 1, 5, 1, 5, 1, 0, 2'b10};
    pats[4] = '{5, 0, 5, 0, 5, 1, 0, 2'b00};
    pats[5] = '{5, 1, 5, 1, 5, 0, 0, 2'b00};
    pats[6] = '{3, 1, 9, 1, 9, 1, 2, 2'b01};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      idle();
      RdM = pats[i].rdm; RegWriteM = pats[i].wm;
      RdW = pats[i].rdw; RegWriteW = pats[i].ww;
      RsE[pats[i].port] = pats[i].rs;
      RsUseE[pats[i].port] = pats[i].use_p;
      e = '0;
      e[pats[i].port] = pats[i].code;
      fwd_q.push_back(e);
      @(negedge clk);
      got = ForwardE;
      e = fwd_q.pop_front();
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL fwd_%0d: got %h want %h", i, got, e);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    idle();
    LoadE = 1; RegWriteE = 1; RdE = 7;
    RsD[1] = 7; RsUseD = 3'b010;
    @(negedge clk);
    n_run++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
      n_fail++;
      $display("FAIL ld_stall: got %b want 1101",
        {StallF, StallD, FlushD, FlushE});
    end
    tick();
    idle();
    RdM = 7; RegWriteM = 1;
    RsD[1] = 7; RsUseD = 3'b010;
    @(negedge clk);
    n_run++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      n_fail++;
      $display("FAIL ld_release: got %b want 000",
        {StallF, StallD, FlushE});
    end
    tick();
    idle();
    RdW = 7; RegWriteW = 1;
    RsE[1] = 7; RsUseE = 3'b010;
    @(negedge clk);
    n_run++;
    if (ForwardE[1] !== 2'b01) begin
      n_fail++;
      $display("FAIL ld_fwd: got %b want 01", ForwardE[1]);
    end
    n_run++;
    if (StallCycles !== 16'd1) begin
      n_fail++;
      $display("FAIL ld_bubble: got %0d want 1", StallCycles);
    end
    tick();
    idle();
    LoadE = 1; RegWriteE = 1; RdE = 0;
    RsD[0] = 0; RsUseD = 3'b001;
    @(negedge clk);
    n_run++;
    if (StallD !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_x0: got %b want 0", StallD);
    end
    tick();
  endtask

  task automatic test_multicycle();
    logic e;
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      idle();
      RsD[0] = 9; RsUseD = 3'b001;
      if (c == 0) begin
        McStartE = 1; RdE = 9;
      end
      if (c == 12) begin
        McDone = 1; McRd = 9;
      end
      stall_q.push_back((c >= 1) && (c <= 12));
      @(negedge clk);
      e = stall_q.pop_front();
      n_run++;
      if (StallD !== e) begin
        n_fail++;
        $display("FAIL mc_stall_c%0d: got %b want %b", c, StallD, e);
      end
      if (c == 1 || c == 13) begin
        n_run++;
        if (McBusy !== (c == 1)) begin
          n_fail++;
          $display("FAIL mc_busy_c%0d: got %b want %b",
            c, McBusy, c == 1);
        end
      end
      if (c == 13) begin
        n_run++;
        if (StallCycles !== 16'd12) begin
          n_fail++;
          $display("FAIL mc_count: got %0d want 12", StallCycles);
        end
      end
      tick();
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    idle();
    McStartE = 1; RdE = 4;
    @(negedge clk);
    n_run++;
    if (StallD !== 1'b0) begin
      n_fail++;
      $display("FAIL sc_start: got %b want 0", StallD);
    end
    tick();
    idle();
    McStartE = 1; RdE = 10;
    @(negedge clk);
    n_run++;
    if ({StallD, FlushE} !== 2'b11) begin
      n_fail++;
      $display("FAIL sc_struct: got %b want 11", {StallD, FlushE});
    end
    tick();
    idle();
    McStartE = 1; RdE = 4; McDone = 1; McRd = 4;
    @(negedge clk);
    n_run++;
    if (StallD !== 1'b0) begin
      n_fail++;
      $display("FAIL sc_swap: got %b want 0", StallD);
    end
    tick();
    idle();
    RsD[0] = 4; RsUseD = 3'b001;
    @(negedge clk);
    n_run++;
    if ({StallD, McBusy} !== 2'b11) begin
      n_fail++;
      $display("FAIL sc_set_wins: got %b want 11", {StallD, McBusy});
    end
    RsD[1] = 10; RsUseD = 3'b010;
    #1;
    n_run++;
    if (StallD !== 1'b0) begin
      n_fail++;
      $display("FAIL sc_no_r10: got %b want 0", StallD);
    end
    tick();
    idle();
    McDone = 1; McRd = 4;
    tick();
    idle();
    RsD[0] = 4; RsUseD = 3'b001;
    @(negedge clk);
    n_run++;
    if ({StallD, McBusy} !== 2'b00) begin
      n_fail++;
      $display("FAIL sc_drain: got %b want 00", {StallD, McBusy});
    end
    tick();
  endtask

  typedef struct {
    logic       a;
    logic [5:0] src;
    logic [2:0] exp;
  } ctl_pat_t;

  task automatic test_control();
    ctl_pat_t pats[8];
    logic [2:0] e;
    logic [2:0] got;
    // src = {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, RVPCSrcE}
    // exp = {StallF, FlushD, FlushE}
    pats[0] = '{1, 6'b100000, 3'b110};
    pats[1] = '{1, 6'b010000, 3'b110};
    pats[2] = '{1, 6'b001000, 3'b110};
    pats[3] = '{1, 6'b000100, 3'b010};
    pats[4] = '{1, 6'b000010, 3'b011};
    pats[5] = '{1, 6'b000001, 3'b000};
    pats[6] = '{0, 6'b000001, 3'b011};
    pats[7] = '{0, 6'b111110, 3'b000};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle();
      arm = pats[i].a;
      {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, RVPCSrcE} =
        pats[i].src;
      ctl_q.push_back(pats[i].exp);
      @(negedge clk);
      got = {StallF, FlushD, FlushE};
      e = ctl_q.pop_front();
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL ctl_%0d: got %b want %b", i, got, e);
      end
      tick();
    end
    idle();
    arm = 1;
    RdM = 15; RegWriteM = 1; RsE[0] = 15; RsUseE = 3'b001;
    @(negedge clk);
    n_run++;
    if (ForwardE[0] !== 2'b00) begin
      n_fail++;
      $display("FAIL arm_pc_fwd: got %b want 00", ForwardE[0]);
    end
    RdM = 0; RsE[0] = 0;
    #1;
    n_run++;
    if (ForwardE[0] !== 2'b10) begin
      n_fail++;
      $display("FAIL arm_r0_fwd: got %b want 10", ForwardE[0]);
    end
    tick();
    arm = 0;
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle();
    McStartE = 1; RdE = 9;
    tick();
    idle();
    RsD[2] = 9; RsUseD = 3'b100;
    @(negedge clk);
    n_run++;
    if (StallD !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_pre: got %b want 1", StallD);
    end
    tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    n_run++;
    if ({StallD, McBusy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rm_post: got %b want 00", {StallD, McBusy});
    end
    n_run++;
    if (StallCycles !== '0) begin
      n_fail++;
      $display("FAIL rm_cnt: got %0d want 0", StallCycles);
    end
    McDone = 1; McRd = 9;
    tick();
    McDone = 0;
    @(negedge clk);
    n_run++;
    if ({StallD, McBusy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rm_late_done: got %b want 00",
        {StallD, McBusy});
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    idle();
    LoadE = 1; RegWriteE = 1; RdE = 7;
    RsD[0] = 7; RsUseD = 3'b001;
    repeat (65534) tick();
    @(negedge clk);
    n_run++;
    if (StallCycles !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL sat_pre: got %h want fffe", StallCycles);
    end
    repeat (6) tick();
    @(negedge clk);
    n_run++;
    if (StallCycles !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_hold: got %h want ffff", StallCycles);
    end
    tick();
    idle();
  endtask

  initial begin
    reset = 1; arm = 0; idle();
    test_reset();
    test_forward();
    test_load_use();
    test_multicycle();
    test_same_cycle();
    test_control();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the combined ARM/RISC-V five-stage pipeline.
- Per-port E-stage forwarding with configurable register count and read-port count.
- Load-use stall.
- Control flush for both ISAs, including ARM PC-write pending.
- Per-register scoreboard that tracks destinations of a variable-latency multi-cycle unit (mul/div), stalling Decode until each result is written back.
- Sits beside the datapath and drives the F/D/E pipeline-register enables and clears.

## Interface
Parameters:
- NREGS, 32: architectural registers; AW = $clog2(NREGS)
- NRD, 3: source read ports per instruction (ARM store/shift-by-register needs 3)
- CW, 16: width of stall performance counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- arm  in  1  1 = ARM mode, 0 = RISC-V mode
- RsD  in  NRD×AW  Decode source registers
- RsUseD  in  NRD  source port p actually read in D
- RsE  in  NRD×AW  Execute source registers
- RsUseE  in  NRD  source port p actually read in E
- RdE, RdM, RdW  in  AW each  destination per stage
- RegWriteE, RegWriteM, RegWriteW  in  1 each
- LoadE  in  1  E instruction is a load
- McStartE  in  1  E instruction issues to multi-cycle unit (dest RdE)
- McDone  in  1  multi-cycle result written to regfile this cycle
- McRd  in  AW  destination of completing multi-cycle result
- RVPCSrcE  in  1  RISC-V taken branch/jump resolved in E
- PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE  in  1 each  ARM PC-write tracking
- ForwardE  out  NRD×2  00 regfile, 10 ALUResultM, 01 ResultW
- StallF, StallD, FlushD, FlushE  out  1 each
- McBusy  out  1  multi-cycle unit occupied
- StallCycles  out  CW  saturating count of cycles with StallD=1

## Operation
Register match:
- Port p matches only if RsUse*[p]=1.
- RISC-V: register 0 never matches, is never set pending and is never forwarded.
- ARM: register 15 never matches; the PC value comes from the datapath.

Forwarding (combinational):
- Per port: M match with RegWriteM gives 10; else W match with RegWriteW gives 01; else 00. M has priority.

Load stall:
- LdStall = LoadE & RegWriteE & any D port matching RdE.

Scoreboard:
- NREGS pending bits plus one busy flag.
- McStartE and StallD=0: set pending[RdE] (unless RISC-V x0) and set busy.
- McDone: clear pending[McRd] and clear busy.
- McStartE and McDone in the same cycle for the same register: set wins. Busy ends 1.
- ScStall = any D port whose register is pending, or (McStartD-class structural conflict, given as McStartE & McBusy & ~McDone).

Outputs:
- StallD = LdStall | ScStall.
- StallF = StallD | (arm & (PCSrcD | PCSrcE | PCSrcM)).
- FlushE = LdStall | ScStall | (arm & BranchTakenE) | (~arm & RVPCSrcE).
- FlushD = arm ? (PCSrcD | PCSrcE | PCSrcM | PCSrcW | BranchTakenE) : RVPCSrcE.
- A flush never clears scoreboard bits. An instruction already in E is committed.

Counter:
- StallCycles increments each cycle StallD=1.
- Saturates at all-ones; no wrap.

## Timing
Reset:
- While reset=1: StallF=StallD=0, FlushD=FlushE=1, ForwardE=all 00.
- Cycle after deassert: all pending bits 0, McBusy=0, StallCycles=0.

Latencies:
- Forwarding, load stall and control: 0-cycle combinational.
- Scoreboard set/clear: registered, visible the cycle after the edge.
- Load-use costs exactly one bubble.
- Multi-cycle dependent instruction leaves D in the cycle after McDone. The regfile is write-first, so no forward is needed.

Boundary cases:
- Reset mid-operation discards pending bits. An in-flight McDone that arrives later is harmless: clearing an already-0 bit.
- Mode change (arm toggled) is legal only with the scoreboard empty. It is not checked.

## Structure
- Package hazard_pkg: forward encodings FWD_RF/FWD_M/FWD_W, ARM_PC_REG=15.
- One sub-module: hz_scoreboard. Holds pending bits, busy flag and set/clear logic, and exposes pending vector and McBusy.
- Top: match, forward, stall/flush logic, counter.

## Test plan
- RISC-V add x5 in M, D/E use x5 on port0 → ForwardE[0]=10. Same with x5 only in W → 01. x0 in M with RegWriteM → 00.
- LoadE RdE=7, RsD[1]=7 used → StallF=StallD=FlushE=1 for one cycle; next cycle ForwardE[1]=01.
- McStartE RdE=9, McDone 12 cycles later McRd=9, RsD=9 waiting → StallD=1 for 12 cycles, 0 the next. StallCycles=12.
- McDone McRd=4 and McStartE RdE=4 same cycle → pending[4] stays 1; D reader of r4 keeps stalling.
- ARM PCSrcD=1 → StallF=1 and FlushD=1 through D/E/M. PCSrcW only → FlushD=1, StallF=0. RsD=15 with RdM=15 → no forward.
- Reset asserted mid-multicycle (pending[9]=1) → after release StallD=0 for reader of r9. StallCycles held at 0xFFFF when saturated.
